// File: rtl/cond_logic.sv
// cond_logic: conditional-execution and status-flag unit for the multicycle core.
// Holds the N/Z/C/V flags written from the ALU, evaluates the instruction condition
// field against them, and gates the controller's PC/register/memory write strobes.
// Optional sticky overflow flag Q is built when COND_LOGIC_QFLAG_EN is defined;
// otherwise Q is tied low and QClear is ignored.
module cond_logic (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic       Negative,
    input  logic       Zero,
    input  logic       Carry,
    input  logic       Overflow,
    input  logic [1:0] FlagW,
    input  logic       CondLatch,
    input  logic       Flush,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       QClear,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags,
    output logic       Q
);

    // Condition field encodings
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;

    // Stored flags, split so the N/Z and C/V halves update independently
    logic [1:0] nz_q, nz_d;
    logic [1:0] cv_q, cv_d;
    logic       cond_ex_reg_q, cond_ex_reg_d;
    logic       cond_ex;

    logic flag_n, flag_z, flag_c, flag_v;
    assign {flag_n, flag_z} = nz_q;
    assign {flag_c, flag_v} = cv_q;

    // Evaluate the condition field against the currently stored flags
    always_comb begin
        // NOTE: default first so every path assigns cond_ex and no latch is inferred.
        cond_ex = 1'b1;
        case (Cond)
            COND_EQ: cond_ex = flag_z;
            COND_NE: cond_ex = ~flag_z;
            COND_CS: cond_ex = flag_c;
            COND_CC: cond_ex = ~flag_c;
            COND_MI: cond_ex = flag_n;
            COND_PL: cond_ex = ~flag_n;
            COND_VS: cond_ex = flag_v;
            COND_VC: cond_ex = ~flag_v;
            COND_HI: cond_ex = flag_c & ~flag_z;
            COND_LS: cond_ex = ~flag_c | flag_z;
            COND_GE: cond_ex = (flag_n == flag_v);
            COND_LT: cond_ex = (flag_n != flag_v);
            COND_GT: cond_ex = ~flag_z & (flag_n == flag_v);
            COND_LE: cond_ex = flag_z | (flag_n != flag_v);
            default: cond_ex = 1'b1;  // AL, and 0xF treated as always
        endcase
    end

    // Next-state for flags and the latched condition; a failed condition blocks flag writes
    always_comb begin
        nz_d          = nz_q;
        cv_d          = cv_q;
        cond_ex_reg_d = cond_ex_reg_q;
        if (FlagW[1] && cond_ex) nz_d = {Negative, Zero};
        if (FlagW[0] && cond_ex) cv_d = {Carry, Overflow};
        // Flush wins; the latched value uses cond_ex from the pre-update flags
        if (Flush)          cond_ex_reg_d = 1'b0;
        else if (CondLatch) cond_ex_reg_d = cond_ex;
    end

    // State registers; async reset also discards a pending latched condition at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nz_q          <= 2'b00;
            cv_q          <= 2'b00;
            cond_ex_reg_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            nz_q          <= nz_d;
            cv_q          <= cv_d;
            cond_ex_reg_q <= cond_ex_reg_d;
        end
    end

`ifdef COND_LOGIC_QFLAG_EN
    logic q_q, q_d;

    // Sticky overflow: set wins over a simultaneous clear
    always_comb begin
        q_d = q_q;
        if (Overflow && FlagW[0] && cond_ex) q_d = 1'b1;
        else if (QClear)                     q_d = 1'b0;
    end

    // Sticky overflow register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q_q <= 1'b0;
        else       q_q <= q_d;
    end

    assign Q = q_q;
`else
    // Feature compiled out: QClear has no effect
    logic unused_qclear;
    assign unused_qclear = QClear;
    assign Q = 1'b0;
`endif

    // Write gating is purely combinational; NextPC bypasses the gate so fetch never stalls
    assign PCWrite  = NextPC | (PCS & cond_ex_reg_q);
    assign RegWrite = RegW & cond_ex_reg_q;
    assign MemWrite = MemW & cond_ex_reg_q;
    assign CondEx   = cond_ex;
    assign Flags    = {nz_q, cv_q};

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed steps, expectations pushed into a
// scoreboard queue when stimulus is applied and popped when the output is sampled.
module tb_cond_logic;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic       Negative, Zero, Carry, Overflow;
    logic [1:0] FlagW;
    logic       CondLatch, Flush, PCS, NextPC, RegW, MemW, QClear;
    logic       PCWrite, RegWrite, MemWrite, CondEx, Q;
    logic [3:0] Flags;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string      tag;
        logic [3:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    cond_logic dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .Negative (Negative),
        .Zero     (Zero),
        .Carry    (Carry),
        .Overflow (Overflow),
        .FlagW    (FlagW),
        .CondLatch(CondLatch),
        .Flush    (Flush),
        .PCS      (PCS),
        .NextPC   (NextPC),
        .RegW     (RegW),
        .MemW     (MemW),
        .QClear   (QClear),
        .PCWrite  (PCWrite),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .CondEx   (CondEx),
        .Flags    (Flags),
        .Q        (Q)
    );

    always #5 clk = ~clk;

    // Push an expected value into the scoreboard
    task automatic expect_val(input string tag, input logic [3:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare it against the observed value
    task automatic check(input logic [3:0] obs);
        sb_entry_t e;
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $error("FAIL scoreboard_empty: observed %h with no expectation queued", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                tests_failed++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Advance one rising edge and sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] sweep_exp;

    initial begin
        reset = 1'b0; Cond = 4'h0;
        Negative = 1'b0; Zero = 1'b0; Carry = 1'b0; Overflow = 1'b0;
        FlagW = 2'b00; CondLatch = 1'b0; Flush = 1'b0;
        PCS = 1'b0; NextPC = 1'b1; RegW = 1'b1; MemW = 1'b0; QClear = 1'b0;

        // 1. Async reset before any clock edge
        #1 reset = 1'b1;
        #1;
        expect_val("reset_flags", 4'b0000);    check(Flags);
        expect_val("reset_q", 4'd0);           check({3'b0, Q});
        expect_val("reset_regwrite", 4'd0);    check({3'b0, RegWrite});
        expect_val("reset_pcwrite", 4'd1);     check({3'b0, PCWrite});
        expect_val("reset_condex_eq", 4'd0);   check({3'b0, CondEx});
        reset = 1'b0; NextPC = 1'b0; RegW = 1'b0;

        // 2. AL with FlagW=10 writes N,Z only
        Cond = 4'hE; Negative = 1'b0; Zero = 1'b1; Carry = 1'b1; Overflow = 1'b1; FlagW = 2'b10;
        tick();
        expect_val("nz_write_flags", 4'b0100); check(Flags);
        FlagW = 2'b00;
        Cond = 4'h0; #1;
        expect_val("eq_after_write", 4'd1);    check({3'b0, CondEx});
        Cond = 4'h1; #1;
        expect_val("ne_after_write", 4'd0);    check({3'b0, CondEx});

        // 3. Failed NE blocks flag writes and the register write
        Negative = 1'b1; Zero = 1'b0; Carry = 1'b1; Overflow = 1'b0;
        FlagW = 2'b11; CondLatch = 1'b1; RegW = 1'b1;
        tick();
        expect_val("failed_cond_flags", 4'b0100); check(Flags);
        expect_val("failed_cond_regwrite", 4'd0); check({3'b0, RegWrite});
        FlagW = 2'b00; CondLatch = 1'b0;

        // 4. Load flags 1001 then sweep every condition code
        Cond = 4'hE; Negative = 1'b1; Zero = 1'b0; Carry = 1'b0; Overflow = 1'b1; FlagW = 2'b11;
        tick();
        expect_val("load_1001", 4'b1001);      check(Flags);
        FlagW = 2'b00;
        sweep_exp = 16'b1101_0110_0101_1010;  // bit i = expected CondEx for Cond=i
        for (int i = 0; i < 16; i++) begin
            Cond = 4'(i);
            #1;
            expect_val($sformatf("sweep_cond_%0h", i), {3'b0, sweep_exp[i]});
            check({3'b0, CondEx});
        end

        // Same-edge flag write and latch: latch sees pre-update flags (GT true on 1001)
        Cond = 4'hC; Negative = 1'b0; Zero = 1'b1; Carry = 1'b1; Overflow = 1'b0;
        FlagW = 2'b11; CondLatch = 1'b1; RegW = 1'b1;
        tick();
        expect_val("same_edge_flags", 4'b0110);     check(Flags);
        expect_val("same_edge_regwrite", 4'd1);     check({3'b0, RegWrite});
        expect_val("same_edge_condex_new", 4'd0);   check({3'b0, CondEx});
        FlagW = 2'b00; CondLatch = 1'b0;

        // Reset mid-instruction drops the latched condition without a clock edge
        @(negedge clk);
        reset = 1'b1; #1;
        expect_val("midreset_regwrite", 4'd0);      check({3'b0, RegWrite});
        expect_val("midreset_flags", 4'b0000);      check(Flags);
        reset = 1'b0; RegW = 1'b0;

        // 5. Flush beats CondLatch, then CondLatch alone enables writes
        Cond = 4'hE; MemW = 1'b1; CondLatch = 1'b1; Flush = 1'b1;
        tick();
        expect_val("flush_priority_memwrite", 4'd0); check({3'b0, MemWrite});
        Flush = 1'b0;
        tick();
        expect_val("latch_memwrite", 4'd1);          check({3'b0, MemWrite});
        PCS = 1'b1; NextPC = 1'b0; #1;
        expect_val("latch_pcwrite_pcs", 4'd1);       check({3'b0, PCWrite});
        CondLatch = 1'b0; Flush = 1'b1;
        tick();
        expect_val("flush_pcwrite", 4'd0);           check({3'b0, PCWrite});
        expect_val("flush_memwrite", 4'd0);          check({3'b0, MemWrite});
        Flush = 1'b0; PCS = 1'b0; MemW = 1'b0;

        // 6. Sticky Q: set wins over clear, hold, then clear alone
        Cond = 4'hE; Overflow = 1'b1; FlagW = 2'b01; QClear = 1'b1;
        tick();
`ifdef COND_LOGIC_QFLAG_EN
        expect_val("q_set_over_clear", 4'd1);
`else
        expect_val("q_set_over_clear", 4'd0);
`endif
        check({3'b0, Q});
        FlagW = 2'b00; Overflow = 1'b0; QClear = 1'b0;
        tick();
`ifdef COND_LOGIC_QFLAG_EN
        expect_val("q_hold", 4'd1);
`else
        expect_val("q_hold", 4'd0);
`endif
        check({3'b0, Q});
        QClear = 1'b1;
        tick();
        expect_val("q_clear", 4'd0);                 check({3'b0, Q});
        QClear = 1'b0;

        if (sb_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
